// File: rtl/round_seq_pkg.sv
// Shared types and the fixed round table for the reaction-game round sequencer.
package round_seq_pkg;

    localparam int MAX_ROUNDS = 8;
    localparam int ENTRY_W    = 16;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_GAP    = 3'd1;
    localparam logic [2:0] S_WINDOW = 3'd2;
    localparam logic [2:0] S_WIN    = 3'd3;
    localparam logic [2:0] S_LOSE   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = S_IDLE,
        GAP    = S_GAP,
        WINDOW = S_WINDOW,
        WIN    = S_WIN,
        LOSE   = S_LOSE
    } state_t;

    typedef enum logic {
        BLUE  = 1'b0,
        GREEN = 1'b1
    } kind_t;

    typedef struct packed {
        logic [ENTRY_W-1:0] gap;
        logic [ENTRY_W-1:0] window;
        kind_t              kind;
    } round_entry_t;

    // Entries past the configured round count are never reached in play.
    localparam round_entry_t ROUND_TABLE [MAX_ROUNDS] = '{
        '{16'd400, 16'd100, BLUE},
        '{16'd400, 16'd50,  BLUE},
        '{16'd250, 16'd25,  BLUE},
        '{16'd375, 16'd25,  GREEN},
        '{16'd75,  16'd100, BLUE},
        '{16'd200, 16'd50,  GREEN},
        '{16'd0,   16'd0,   BLUE},
        '{16'd0,   16'd0,   BLUE}
    };

    function automatic logic [ENTRY_W-1:0] atLeastOne(input logic [ENTRY_W-1:0] d);
        return (d == '0) ? ENTRY_W'(1) : d;
    endfunction

endpackage

// File: rtl/round_sequencer_tick_prescaler.sv
// Divide-by-PRESCALE tick generator with run enable and synchronous clear.
module tick_prescaler #(
    parameter int PRESCALE = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] count;

    always_comb begin
        tick = enable && (count == LAST);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/round_sequencer.sv
// Prescaled, pausable gap/window phase FSM scoring the player button per round.
// Defining ROUND_SEQ_FALSE_START_EN makes a press during GAP an immediate loss.
module round_sequencer
    import round_seq_pkg::*;
#(
    parameter int NUM_ROUNDS = 6,
    parameter int PRESCALE   = 1000000,
    parameter int TICK_W     = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_signal,
    input  logic       player_reaction,
    output logic       in_blue_round,
    output logic       in_green_round,
    output logic       win_signal,
    output logic       lose_signal,
    output logic [2:0] round_idx,
    output logic       busy
);

    state_t             state;
    state_t             nextState;
    logic [2:0]         nextIdx;
    logic [TICK_W-1:0]  tickCount;
    logic [TICK_W-1:0]  phaseLen;
    logic               hit;
    logic               tick;
    logic               running;
    logic               pressNow;
    logic               phaseDone;
    logic               lastRound;
    logic               advance;
    logic               phaseChange;
    round_entry_t       entry;
    round_entry_t       nextEntry;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) prescaler (
        .clock (clock),
        .reset (reset),
        .enable(running),
        .clear (phaseChange),
        .tick  (tick)
    );

    always_comb begin
        entry     = ROUND_TABLE[round_idx];
        running   = start_signal && (state == GAP || state == WINDOW);
        pressNow  = running && player_reaction;
        lastRound = (round_idx == 3'(NUM_ROUNDS - 1));
        phaseLen  = (state == GAP) ? TICK_W'(atLeastOne(entry.gap))
                                   : TICK_W'(atLeastOne(entry.window));
        phaseDone = tick && (tickCount == phaseLen - TICK_W'(1));

        nextState = state;
        nextIdx   = round_idx;
        advance   = 1'b0;

        case (state)
            IDLE: begin
                if (start_signal) nextState = GAP;
            end
            GAP: begin
`ifdef ROUND_SEQ_FALSE_START_EN
                if (pressNow) nextState = LOSE;
                else
`endif
                if (phaseDone) nextState = WINDOW;
            end
            WINDOW: begin
                // A press on the closing cycle still counts: LOSE beats advance on GREEN.
                if (entry.kind == GREEN) begin
                    if (pressNow)       nextState = LOSE;
                    else if (phaseDone) advance   = 1'b1;
                end else if (phaseDone) begin
                    if (hit || pressNow) advance   = 1'b1;
                    else                 nextState = LOSE;
                end
            end
            default: nextState = state;
        endcase

        if (advance) begin
            if (lastRound) begin
                nextState = WIN;
            end else begin
                nextState = GAP;
                nextIdx   = round_idx + 3'd1;
            end
        end

        phaseChange = (nextState != state) || advance;
        nextEntry   = ROUND_TABLE[nextIdx];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            round_idx      <= '0;
            tickCount      <= '0;
            hit            <= 1'b0;
            in_blue_round  <= 1'b0;
            in_green_round <= 1'b0;
            win_signal     <= 1'b0;
            lose_signal    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state     <= nextState;
            round_idx <= nextIdx;

            if (phaseChange)  tickCount <= '0;
            else if (tick)    tickCount <= tickCount + TICK_W'(1);

            if (state == GAP && nextState == WINDOW)  hit <= 1'b0;
            else if (state == WINDOW && pressNow)     hit <= 1'b1;

            in_blue_round  <= (nextState == WINDOW) && (nextEntry.kind == BLUE);
            in_green_round <= (nextState == WINDOW) && (nextEntry.kind == GREEN);
            win_signal     <= (nextState == WIN);
            lose_signal    <= (nextState == LOSE);
            busy           <= (nextState == GAP) || (nextState == WINDOW);
        end
    end

endmodule

// File: doc/round_sequencer.md
# round_sequencer

Programmable round scheduler for the reaction game. It sequences a fixed table of gap/window phases and drives the blue/green round indications consumed by the VGA controller. It scores the player's button against each window and issues the terminal win/lose verdict. It replaces absolute-timer compare logic with a prescaled, pausable phase FSM.

## Interface
- NUM_ROUNDS, 6, rounds in the table; at most 8.
- PRESCALE, 1000000, clock cycles per tick; minimum 1.
- TICK_W, 16, width of the per-phase tick counter and of table durations.
- clock  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- start_signal  in  1  run enable, level-sensitive; low pauses all counting.
- player_reaction  in  1  player button, level, synchronous to clock.
- in_blue_round  out  1  high during a press-required window.
- in_green_round  out  1  high during a must-not-press window.
- win_signal  out  1  sticky win verdict.
- lose_signal  out  1  sticky lose verdict.
- round_idx  out  3  index of the current round (0-based).
- busy  out  1  high from leaving IDLE until WIN or LOSE is reached.

## Operation
- Round table (package constant, entries 0..5): gap/window ticks and kind.
  - Entry 0: 400/100 BLUE.
  - Entry 1: 400/50 BLUE.
  - Entry 2: 250/25 BLUE.
  - Entry 3: 375/25 GREEN.
  - Entry 4: 75/100 BLUE.
  - Entry 5: 200/50 GREEN.
- A duration of 0 is treated as 1.
- States: IDLE, GAP, WINDOW, WIN, LOSE.
- IDLE: start_signal=1 -> GAP with round_idx=0.
- GAP: after gap ticks elapse -> WINDOW; clear the hit flag.
- WINDOW, BLUE kind:
  - Any running cycle with player_reaction=1 sets the hit flag.
  - At window end, hit=1 -> next round's GAP, or WIN if this is the last round.
  - At window end, hit=0 -> LOSE.
- WINDOW, GREEN kind:
  - player_reaction=1 on any running cycle -> LOSE immediately.
  - At window end -> next round's GAP, or WIN if this is the last round.
- WIN and LOSE are terminal; only reset leaves them.
- Presses during GAP are ignored unless the configuration macro below is defined.
- While start_signal=0 in GAP or WINDOW:
  - The prescaler, tick counter and state all hold.
  - player_reaction is ignored.
  - Outputs hold their values.

## Timing
- Reset values: every output 0, round_idx=0, state IDLE, counters 0.
- Outputs are registered and reflect the state entered on the preceding edge.
  - in_blue_round = state==WINDOW and kind==BLUE.
  - in_green_round = state==WINDOW and kind==GREEN.
- The prescaler and tick counter clear on every phase entry.
- A phase of D ticks occupies exactly D*PRESCALE running cycles.
- Transitions happen on the edge that completes the final prescaler count of the last tick.
- A press on the last cycle of a BLUE window counts as a hit.
- A press on the last cycle of a GREEN window causes LOSE, since LOSE takes priority over advancing.
- With PRESCALE=1, GAP is entered on edge 0 (the edge where start_signal is sampled high).
  - in_blue_round rises after edge G.
  - in_blue_round falls after edge G+W.
- Asynchronous reset mid-operation returns to IDLE with all outputs 0 at once.

## Configuration
- ROUND_SEQ_FALSE_START_EN defined:
  - player_reaction=1 on any running GAP cycle -> LOSE next edge.
- ROUND_SEQ_FALSE_START_EN undefined:
  - Presses during GAP are ignored.

## Structure
- Shared package round_seq_pkg holds:
  - the state enum;
  - the kind enum (BLUE, GREEN);
  - the round-entry struct {gap, window, kind};
  - the ROUND_TABLE constant;
  - the MAX_ROUNDS constant.
- One sub-module, tick_prescaler:
  - free-running divide-by-PRESCALE counter with enable and synchronous clear;
  - emits a one-cycle tick pulse.
- The FSM, tick counter and hit flag live in round_sequencer.

## Test plan
All scenarios use PRESCALE=1.
- Press held for 5 cycles inside every BLUE window, none elsewhere -> win_signal=1 after the final window, at 2050 running cycles; lose_signal stays 0.
- No press at all -> in_blue_round high for 100 cycles, then lose_signal=1 at cycle 500; round_idx=0.
- Correct play through round 2, then a one-cycle press at the 10th cycle of the round-3 GREEN window -> lose_signal=1 one edge later; in_green_round=0.
- start_signal dropped for 37 cycles in the middle of round 0's window -> window length measured in clock cycles is 137; the verdict is unchanged.
- Press only on the last cycle of a BLUE window -> the hit counts and the sequencer advances. Press only on the last cycle of a GREEN window -> LOSE.
- Reset asserted mid-WINDOW of round 4 -> all outputs 0 immediately and round_idx=0. With ROUND_SEQ_FALSE_START_EN defined, a press in GAP -> LOSE.
